// File: rtl/rtc_reg_init_seq.sv
// rtc_reg_init_seq
// ----------------
// Register-initialisation sequencer for the RTC bus. On an accepted start it
// walks BASE_ADDR .. BASE_ADDR+NUM_REGS-1. For each address it gives one
// address-setup cycle, a RD strobe of RD_CYCLES, a WR strobe of WR_CYCLES
// carrying the fill value, an optional read-back (verify) strobe, then
// GAP_CYCLES idle cycles. The bus is owned (reinicio) for the whole walk.
//
// Optional feature macro: RTC_INIT_VERIFY_EN
//   defined   : VFY state after each write; rd_data is compared with data_out
//               on the last VFY cycle, first mismatch latched in err/err_addr.
//   undefined : no VFY state, err/err_addr stay 0, rd_data is ignored.
//
// Ports
//   clk, reset        : clock (rising edge), async active-low reset
//   start, abort      : level request / terminate (abort has priority)
//   mode, fill_data   : fill select (0 = zeros, 1 = fill_data), sampled on start
//   rd_data           : bus read data (verify only)
//   dir_out, data_out : bus address / write data
//   RD, WR            : bus strobes (never high together)
//   reinicio, busy    : bus ownership / sequence in progress
//   ready, aborted    : done flag / sticky abort flag
//   err, err_addr     : verify result
module rtc_reg_init_seq #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int BASE_ADDR  = 0,
    parameter int NUM_REGS   = 4,
    parameter int RD_CYCLES  = 257,
    parameter int WR_CYCLES  = 256,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [DATA_W-1:0] fill_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] dir_out,
    output logic [DATA_W-1:0] data_out,
    output logic              RD,
    output logic              WR,
    output logic              reinicio,
    output logic              busy,
    output logic              ready,
    output logic              aborted,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int MAX_RW = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int MAX_C  = (MAX_RW > GAP_CYCLES) ? MAX_RW : GAP_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    localparam longint LAST_L    = longint'(BASE_ADDR) + longint'(NUM_REGS) - 1;
    localparam longint ADDR_SPAN = longint'(1) << ADDR_W;

    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_L);

    // Counter reload values are "cycles - 1": a phase ends when the count is 0.
    localparam logic [CNT_W-1:0] RD_LD  = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    // Window must fit the address space (no wrap) and timing must be legal.
    generate
        if (NUM_REGS < 1 || RD_CYCLES < 1 || WR_CYCLES < 1 || GAP_CYCLES < 0 ||
            LAST_L >= ADDR_SPAN) begin : g_bad_cfg
            $error("rtc_reg_init_seq: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RDPH,
        S_WRPH,
`ifdef RTC_INIT_VERIFY_EN
        S_VFY,
`endif
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [ADDR_W-1:0]  dir_q,      dir_d;
    logic [DATA_W-1:0]  data_q,     data_d;
    logic               rd_q,       rd_d;
    logic               wr_q,       wr_d;
    logic               busy_q,     busy_d;
    logic               ready_q,    ready_d;
    logic               aborted_q,  aborted_d;
    logic               err_q,      err_d;
    logic [ADDR_W-1:0]  err_addr_q, err_addr_d;

    // go_post_wr: a write (and its verify) finished, choose GAP or next address.
    // go_next   : the current register is complete, advance or finish.
    logic go_post_wr;
    logic go_next;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        data_d     = data_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        aborted_d  = aborted_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        go_post_wr = 1'b0;
        go_next    = 1'b0;

        if (abort) begin
            state_d   = S_IDLE;
            rd_d      = 1'b0;
            wr_d      = 1'b0;
            busy_d    = 1'b0;
            ready_d   = 1'b0;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d    = S_ADDR;
                        data_d     = mode ? fill_data : '0;
                        dir_d      = BASE_A;
                        busy_d     = 1'b1;
                        ready_d    = 1'b0;
                        aborted_d  = 1'b0;
                        err_d      = 1'b0;
                        err_addr_d = '0;
                    end
                end
                S_ADDR: begin
                    state_d = S_RDPH;
                    rd_d    = 1'b1;
                    cnt_d   = RD_LD;
                end
                S_RDPH: begin
                    if (cnt_q == '0) begin
                        state_d = S_WRPH;
                        rd_d    = 1'b0;
                        wr_d    = 1'b1;
                        cnt_d   = WR_LD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_WRPH: begin
                    if (cnt_q == '0) begin
                        wr_d = 1'b0;
`ifdef RTC_INIT_VERIFY_EN
                        state_d = S_VFY;
                        rd_d    = 1'b1;
                        cnt_d   = RD_LD;
`else
                        go_post_wr = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`ifdef RTC_INIT_VERIFY_EN
                S_VFY: begin
                    if (cnt_q == '0) begin
                        rd_d       = 1'b0;
                        go_post_wr = 1'b1;
                        // Only the first mismatch is recorded.
                        if (rd_data != data_q && !err_q) begin
                            err_d      = 1'b1;
                            err_addr_d = dir_q;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
`endif
                S_GAP: begin
                    if (cnt_q == '0) go_next = 1'b1;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = S_IDLE;
            endcase

            if (go_post_wr) begin
                if (GAP_CYCLES > 0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    go_next = 1'b1;
                end
            end

            if (go_next) begin
                if (dir_q == LAST_ADDR) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    state_d = S_ADDR;
                    dir_d   = dir_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dir_q      <= '0;
            data_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            aborted_q  <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            data_q     <= data_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            aborted_q  <= aborted_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

`ifndef RTC_INIT_VERIFY_EN
    logic unused_rd_data;
    assign unused_rd_data = ^rd_data;
`endif

    // Bus ownership tracks busy exactly, so both come from the same flop.
    assign dir_out  = dir_q;
    assign data_out = data_q;
    assign RD       = rd_q;
    assign WR       = wr_q;
    assign reinicio = busy_q;
    assign busy     = busy_q;
    assign ready    = ready_q;
    assign aborted  = aborted_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_rtc_reg_init_seq.sv
// Directed/randomised bench for rtc_reg_init_seq. Two instances with
// different windows and timings run side by side; expected outputs for any
// cycle come from a closed-form timeline model (period arithmetic).
module tb_rtc_reg_init_seq;

`ifdef RTC_INIT_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    // Instance A: base 0, 4 regs, RD=3 WR=2 GAP=1
    localparam int A_BASE = 0,  A_N = 4, A_RD = 3, A_WR = 2, A_GAP = 1;
    // Instance B: base 0x10, 2 regs, RD=2 WR=1, no gap
    localparam int B_BASE = 16, B_N = 2, B_RD = 2, B_WR = 1, B_GAP = 0;

    localparam int A_P = 1 + A_RD + A_WR + A_GAP + (VFY ? A_RD : 0);
    localparam int B_P = 1 + B_RD + B_WR + B_GAP + (VFY ? B_RD : 0);
    localparam int K_END = ((A_N * A_P > B_N * B_P) ? A_N * A_P : B_N * B_P) + 2;

    typedef struct packed {
        logic [7:0] dir;
        logic [7:0] data;
        logic       rd;
        logic       wr;
        logic       rei;
        logic       busy;
        logic       ready;
        logic       abt;
        logic       err;
        logic [7:0] eaddr;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] fill_data = 8'h00;
    logic [7:0] rd_data_a, rd_data_b;
    logic       corrupt_en = 1'b0;
    int         errk_sel = 0;

    logic [7:0] dir_a, data_a, eaddr_a, dir_b, data_b, eaddr_b;
    logic       rd_a, wr_a, rei_a, busy_a, ready_a, abt_a, err_a;
    logic       rd_b, wr_b, rei_b, busy_b, ready_b, abt_b, err_b;

    int errors = 0;
    int checks = 0;
    obs_t last_a, last_b;

    always #5 clk = ~clk;

    // Read-back: echo write data, optionally corrupted at one address of A.
    assign rd_data_a = (corrupt_en && dir_a == 8'(A_BASE + errk_sel)) ? ~data_a : data_a;
    assign rd_data_b = data_b;

    rtc_reg_init_seq #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(A_BASE), .NUM_REGS(A_N),
                       .RD_CYCLES(A_RD), .WR_CYCLES(A_WR), .GAP_CYCLES(A_GAP)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .fill_data(fill_data), .rd_data(rd_data_a), .dir_out(dir_a), .data_out(data_a),
        .RD(rd_a), .WR(wr_a), .reinicio(rei_a), .busy(busy_a), .ready(ready_a),
        .aborted(abt_a), .err(err_a), .err_addr(eaddr_a));

    rtc_reg_init_seq #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(B_BASE), .NUM_REGS(B_N),
                       .RD_CYCLES(B_RD), .WR_CYCLES(B_WR), .GAP_CYCLES(B_GAP)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .fill_data(fill_data), .rd_data(rd_data_b), .dir_out(dir_b), .data_out(data_b),
        .RD(rd_b), .WR(wr_b), .reinicio(rei_b), .busy(busy_b), .ready(ready_b),
        .aborted(abt_b), .err(err_b), .err_addr(eaddr_b));

    obs_t obs_a, obs_b;
    assign obs_a = '{dir_a, data_a, rd_a, wr_a, rei_a, busy_a, ready_a, abt_a, err_a, eaddr_a};
    assign obs_b = '{dir_b, data_b, rd_b, wr_b, rei_b, busy_b, ready_b, abt_b, err_b, eaddr_b};

    // Expected outputs after edge k of a run whose start was taken at edge 0.
    // errk = index of the register whose read-back mismatches (-1 = none).
    function automatic obs_t model(int k, int base, int n, int rdc, int wrc, int gapc,
                                   logic [7:0] d, int errk);
        obs_t o;
        int p, r, ph;
        p = 1 + rdc + wrc + gapc + (VFY ? rdc : 0);
        o = '0;
        o.data = d;
        if (k >= n * p) begin
            o.dir   = 8'(base + n - 1);
            o.ready = 1'b1;
        end else begin
            r  = k / p;
            ph = k % p;
            o.dir  = 8'(base + r);
            o.busy = 1'b1;
            o.rei  = 1'b1;
            o.rd   = (ph >= 1 && ph <= rdc) ||
                     (VFY && ph > rdc + wrc && ph <= 2 * rdc + wrc);
            o.wr   = (ph > rdc && ph <= rdc + wrc);
        end
        if (VFY && errk >= 0 && k >= errk * p + 1 + 2 * rdc + wrc) begin
            o.err   = 1'b1;
            o.eaddr = 8'(base + errk);
        end
        return o;
    endfunction

    function automatic obs_t after_abort(obs_t o);
        obs_t x;
        x = o;
        x.rd = 1'b0; x.wr = 1'b0; x.rei = 1'b0; x.busy = 1'b0; x.ready = 1'b0;
        x.abt = 1'b1;
        return x;
    endfunction

    task automatic ck(input string tag, input obs_t got, input obs_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller sets start=1 before calling. restart_k: first edge of a 3-edge
    // start re-assertion while busy (-1 = none). fill_data/mode wander mid-run.
    task automatic run(input string tag, input logic [7:0] d, input int errk,
                       input int restart_k);
        int em;
        em = VFY ? errk : -1;
        for (int k = 0; k <= K_END; k++) begin
            tick();
            last_a = model(k, A_BASE, A_N, A_RD, A_WR, A_GAP, d, em);
            last_b = model(k, B_BASE, B_N, B_RD, B_WR, B_GAP, d, -1);
            ck({tag, "_a"}, obs_a, last_a);
            ck({tag, "_b"}, obs_b, last_b);
            start     = (restart_k >= 0 && k + 1 >= restart_k && k + 1 < restart_k + 3);
            fill_data = 8'($urandom);
            mode      = 1'($urandom);
        end
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int ka, ek;
        obs_t pa, pb;

        // Reset state
        #3;
        ck("reset_a", obs_a, '0);
        ck("reset_b", obs_b, '0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        ck("idle_a", obs_a, '0);
        ck("idle_b", obs_b, '0);

        // Run 1: zero fill, start re-asserted while busy is ignored
        mode = 1'b0; fill_data = 8'($urandom); start = 1'b1;
        run("zero", 8'h00, -1, 3);

        // Run 2: random fill, accepted from DONE
        d = 8'($urandom); mode = 1'b1; fill_data = d; start = 1'b1;
        run("fill", d, -1, -1);

        // Run 3: abort in the second WR phase of A (B already DONE)
        d = 8'($urandom); mode = 1'b1; fill_data = d; start = 1'b1;
        ka = A_P + A_RD + 1 + $urandom_range(0, A_WR - 1) + 1;
        for (int k = 0; k < ka; k++) begin
            tick();
            pa = model(k, A_BASE, A_N, A_RD, A_WR, A_GAP, d, -1);
            pb = model(k, B_BASE, B_N, B_RD, B_WR, B_GAP, d, -1);
            ck("pre_abort_a", obs_a, pa);
            ck("pre_abort_b", obs_b, pb);
            start = 1'b0;
            abort = (k + 1 == ka);
        end
        tick();
        abort = 1'b0;
        ck("abort_a", obs_a, after_abort(pa));
        ck("abort_b", obs_b, after_abort(pb));
        tick();
        ck("abort_hold_a", obs_a, after_abort(pa));
        ck("abort_hold_b", obs_b, after_abort(pb));

        // Run 4: restart after abort, fill 3C, read-back mismatch at one address
        ek = $urandom_range(0, A_N - 1);
        errk_sel = ek; corrupt_en = 1'b1;
        mode = 1'b1; fill_data = 8'h3C; start = 1'b1;
        run("verify", 8'h3C, ek, -1);
        corrupt_en = 1'b0;

        // start+abort at DONE, then again in IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        ck("sa_done_a", obs_a, after_abort(last_a));
        ck("sa_done_b", obs_b, after_abort(last_b));
        tick();
        ck("sa_idle_a", obs_a, after_abort(last_a));
        ck("sa_idle_b", obs_b, after_abort(last_b));
        start = 1'b0; abort = 1'b0;

        // Reset during RD phase of A
        d = 8'($urandom); mode = 1'b1; fill_data = d; start = 1'b1;
        tick();
        start = 1'b0;
        ck("pre_rst_a", obs_a, model(0, A_BASE, A_N, A_RD, A_WR, A_GAP, d, -1));
        tick();
        ck("pre_rst_rd_a", obs_a, model(1, A_BASE, A_N, A_RD, A_WR, A_GAP, d, -1));
        #2 reset = 1'b0;
        #1;
        ck("async_rst_a", obs_a, '0);
        ck("async_rst_b", obs_b, '0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            ck("post_rst_a", obs_a, '0);
            ck("post_rst_b", obs_b, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
